fetch_sequencer: RTL

Instruction-fetch controller for the multicycle CPU. It owns the program counter and drives the word address into the asynchronous-read instruction memory. It holds that address stable for a configurable number of settle cycles, then latches the returned word into the instruction register. The main control FSM requests one fetch at a time and can redirect the PC for branches and jumps.

---
 rtl/fetch_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, holds the fetch address for a
// programmable settle time, then latches the returned word.
module fetch_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_busy,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       fetch_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] pc_n;
    logic [DATA_W-1:0] instr_n;
    logic              valid_n;
    logic [15:0]       count_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc;
        instr_n = instr;
        valid_n = 1'b0;
        count_n = fetch_count;
        case (state)
            ST_IDLE: begin
                // a redirect drops any fetch request in the same cycle
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                end else if (fetch_req) begin
                    state_n = ST_WAIT;
                    cnt_n   = '0;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = ST_IDLE;
                end else if (cnt == LAST) begin
                    instr_n = read_data;
                    pc_n    = pc + ADDR_W'(1);
                    count_n = fetch_count + 16'd1;
                    valid_n = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign inst_address = pc;
    assign fetch_busy   = (state == ST_WAIT);

endmodule
